// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with a combinational lookup, single-cycle refill,
// fill-to-lookup bypass, and a one-set-per-cycle invalidation walk for fence.i.
module icache_2way #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              fill_valid,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_ready,
  input  logic              flush_req,
  output logic              flush_busy
);
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int SETS  = 1 << INDEX_W;

  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;

  logic [SETS-1:0]   valid0, valid1, lru;
  logic [TAG_W-1:0]  tag0  [SETS];
  logic [TAG_W-1:0]  tag1  [SETS];
  logic [DATA_W-1:0] data0 [SETS];
  logic [DATA_W-1:0] data1 [SETS];

  logic [INDEX_W-1:0] l_idx, f_idx;
  logic [TAG_W-1:0]   l_tag, f_tag;
  logic flushing, fill_acc, bypass, lookup_ok;
  logic l_hit0, l_hit1, f_m0, f_m1, hit_way, fill_way;
  logic unused_bits;

  assign l_idx = lookup_addr[INDEX_W+1:2];
  assign l_tag = lookup_addr[ADDR_W-1:INDEX_W+2];
  assign f_idx = fill_addr[INDEX_W+1:2];
  assign f_tag = fill_addr[ADDR_W-1:INDEX_W+2];
  assign unused_bits = ^{lookup_addr[1:0], fill_addr[1:0]};

  assign flushing   = (state_q == FLUSH);
  assign flush_busy = !rst && flushing;
  // A flush request wins over a fill arriving in the same cycle.
  assign fill_ready = !rst && !flushing && !flush_req;
  assign fill_acc   = fill_valid && fill_ready;

  assign l_hit0    = valid0[l_idx] && (tag0[l_idx] == l_tag);
  assign l_hit1    = valid1[l_idx] && (tag1[l_idx] == l_tag);
  assign bypass    = fill_acc && (f_idx == l_idx) && (f_tag == l_tag);
  assign lookup_ok = lookup_valid && !rst && !flushing;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    hit_way  = 1'b0;
    if (lookup_ok) begin
      if (bypass) begin
        hit      = 1'b1;
        hit_data = fill_data;
      end else if (l_hit0) begin
        hit      = 1'b1;
        hit_data = data0[l_idx];
      end else if (l_hit1) begin
        hit      = 1'b1;
        hit_data = data1[l_idx];
        hit_way  = 1'b1;
      end
    end
  end

  // Reuse the way already holding the tag so a line can never be duplicated.
  assign f_m0 = valid0[f_idx] && (tag0[f_idx] == f_tag);
  assign f_m1 = valid1[f_idx] && (tag1[f_idx] == f_tag);

  always_comb begin
    fill_way = lru[f_idx];
    if (f_m0)                fill_way = 1'b0;
    else if (f_m1)           fill_way = 1'b1;
    else if (!valid0[f_idx]) fill_way = 1'b0;
    else if (!valid1[f_idx]) fill_way = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (flush_req) begin
        state_d = FLUSH;
        cnt_d   = '0;
      end
      FLUSH: begin
        cnt_d = cnt_q + INDEX_W'(1);
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fill LRU write comes after the hit update so it wins on a same-set collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else if (flushing) begin
      valid0[cnt_q] <= 1'b0;
      valid1[cnt_q] <= 1'b0;
      lru[cnt_q]    <= 1'b0;
    end else begin
      if (hit && !bypass) lru[l_idx] <= ~hit_way;
      if (fill_acc) begin
        if (fill_way) valid1[f_idx] <= 1'b1;
        else          valid0[f_idx] <= 1'b1;
        lru[f_idx] <= ~fill_way;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_acc) begin
      if (fill_way) begin
        tag1[f_idx]  <= f_tag;
        data1[f_idx] <= fill_data;
      end else begin
        tag0[f_idx]  <= f_tag;
        data0[f_idx] <= fill_data;
      end
    end
  end
endmodule

// File: tb/tb_icache_2way.sv
// Directed bench for icache_2way: miss/hit, LRU replacement, overwrite, bypass, flush walk, reset abort.
module tb_icache_2way;
  logic        clk = 1'b0, rst = 1'b1;
  logic        lookup_valid = 1'b0, fill_valid = 1'b0, flush_req = 1'b0;
  logic [31:0] lookup_addr = '0, fill_addr = '0, fill_data = '0;
  logic        hit, fill_ready, flush_busy;
  logic [31:0] hit_data;
  int n_chk = 0, n_fail = 0;
  int busy_cnt;

  icache_2way dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr),
    .hit(hit), .hit_data(hit_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_ready(fill_ready),
    .flush_req(flush_req), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    lookup_valid = 1'b0;
    fill_valid   = 1'b0;
    flush_req    = 1'b0;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    idle_in();
    fill_valid = 1'b1; fill_addr = a; fill_data = d;
    #1 chk("fill_ready", {31'd0, fill_ready}, 32'd1);
    @(posedge clk);
    #1 idle_in();
  endtask

  task automatic lookup(input string tag, input logic [31:0] a,
                        input logic eh, input logic [31:0] ed);
    @(negedge clk);
    idle_in();
    lookup_valid = 1'b1; lookup_addr = a;
    #1;
    chk({tag, "_hit"}, {31'd0, hit}, {31'd0, eh});
    chk({tag, "_data"}, hit_data, ed);
    @(posedge clk);
    #1 idle_in();
  endtask

  initial begin
    // reset: outputs forced low while rst is high
    rst = 1'b1;
    @(negedge clk);
    lookup_valid = 1'b1; lookup_addr = 32'h1000; fill_valid = 1'b1; fill_addr = 32'h1000;
    #1;
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_fill_ready", {31'd0, fill_ready}, 32'd0);
    chk("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
    @(posedge clk);
    #1 idle_in();
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_busy", {31'd0, flush_busy}, 32'd0);

    // basic miss then fill then hit
    lookup("cold", 32'h1000, 1'b0, 32'h0);
    fill(32'h1000, 32'hDEADBEEF);
    lookup("warm", 32'h1000, 1'b1, 32'hDEADBEEF);

    // LRU: 0x1000 way0, 0x2000 way1, touch 0x1000, then 0x3000 evicts 0x2000
    fill(32'h2000, 32'h22222222);
    lookup("touch1000", 32'h1000, 1'b1, 32'hDEADBEEF);
    fill(32'h3000, 32'h33333333);
    lookup("evict2000", 32'h2000, 1'b0, 32'h0);
    lookup("keep1000", 32'h1000, 1'b1, 32'hDEADBEEF);
    lookup("new3000", 32'h3000, 1'b1, 32'h33333333);

    // refill of a resident tag rewrites its own way only
    fill(32'h1000, 32'hAAAAAAAA);
    fill(32'h1000, 32'hBBBBBBBB);
    lookup("rewrite1000", 32'h1000, 1'b1, 32'hBBBBBBBB);
    lookup("other3000", 32'h3000, 1'b1, 32'h33333333);

    // same-cycle fill/lookup bypass; 0x3000 was touched last so 0x1000 is the victim
    @(negedge clk);
    lookup_valid = 1'b1; lookup_addr = 32'h4000;
    fill_valid = 1'b1; fill_addr = 32'h4000; fill_data = 32'h12345678;
    #1;
    chk("bypass_hit", {31'd0, hit}, 32'd1);
    chk("bypass_data", hit_data, 32'h12345678);
    @(posedge clk);
    #1 idle_in();
    lookup("after_bypass", 32'h4000, 1'b1, 32'h12345678);
    lookup("victim1000", 32'h1000, 1'b0, 32'h0);
    lookup("kept3000", 32'h3000, 1'b1, 32'h33333333);

    // other sets, including the last one
    fill(32'h1004, 32'h11111111);
    fill(32'h10FC, 32'h63636363);
    lookup("set1", 32'h1004, 1'b1, 32'h11111111);
    lookup("set63", 32'h10FC, 1'b1, 32'h63636363);

    // flush: a fill in the request cycle is refused; a second request mid-walk is ignored
    @(negedge clk);
    fill_valid = 1'b1; fill_addr = 32'h5000; fill_data = 32'h55555555; flush_req = 1'b1;
    #1 chk("flush_req_fill_ready", {31'd0, fill_ready}, 32'd0);
    @(posedge clk);
    #1 idle_in();
    busy_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      lookup_valid = 1'b1; lookup_addr = 32'h3000;
      flush_req = (c == 5);
      #1;
      if (!flush_busy) break;
      busy_cnt++;
      if (c == 0 || c == 63) begin
        chk("flush_fill_ready", {31'd0, fill_ready}, 32'd0);
        chk("flush_hit", {31'd0, hit}, 32'd0);
      end
      @(posedge clk);
      #1 flush_req = 1'b0;
    end
    idle_in();
    chk("flush_len", busy_cnt, 32'd64);
    lookup("fl_3000", 32'h3000, 1'b0, 32'h0);
    lookup("fl_4000", 32'h4000, 1'b0, 32'h0);
    lookup("fl_5000", 32'h5000, 1'b0, 32'h0);
    lookup("fl_set1", 32'h1004, 1'b0, 32'h0);
    lookup("fl_set63", 32'h10FC, 1'b0, 32'h0);

    // reset aborts a walk at cycle 10 and still clears sets the walk had not reached
    fill(32'h20FC, 32'h20FC20FC);
    lookup("pre_abort", 32'h20FC, 1'b1, 32'h20FC20FC);
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk);
    #1 idle_in();
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_busy_in_rst", {31'd0, flush_busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_busy_after", {31'd0, flush_busy}, 32'd0);
    lookup("abort_20FC", 32'h20FC, 1'b0, 32'h0);
    fill(32'h2000, 32'h77777777);
    lookup("abort_fill", 32'h2000, 1'b1, 32'h77777777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_2way.md
ICACHE_2WAY -- requirements
Module: icache_2way

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter INDEX_W, default 6, set-index width; 2^INDEX_W sets.
REQ-003 SHALL have parameter DATA_W, default 32, line (instruction word) width.
REQ-004 SHALL derive TAG_W = ADDR_W - INDEX_W - 2; index = addr[INDEX_W+1:2], tag = addr[ADDR_W-1:INDEX_W+2].
REQ-005 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port lookup_valid  input  1  lookup request qualifier.
REQ-008 SHALL have port lookup_addr  input  ADDR_W  fetch address.
REQ-009 SHALL have port hit  output  1  lookup hit, combinational.
REQ-010 SHALL have port hit_data  output  DATA_W  hit word, combinational.
REQ-011 SHALL have port fill_valid  input  1  refill write request.
REQ-012 SHALL have port fill_addr  input  ADDR_W  refill address.
REQ-013 SHALL have port fill_data  input  DATA_W  refill word.
REQ-014 SHALL have port fill_ready  output  1  fill accepted this cycle when fill_valid=1.
REQ-015 SHALL have port flush_req  input  1  invalidate-all request (fence.i), one-cycle pulse.
REQ-016 SHALL have port flush_busy  output  1  invalidation walk in progress.

Function
REQ-017 SHALL store per set two ways (valid, tag, data) and one LRU bit (0 = way0 least recent).
REQ-018 SHALL assert hit when lookup_valid=1, not flushing, and a valid way tag matches; hit_data = that way's data; else hit=0, hit_data=0.
REQ-019 SHALL, when fill_valid=1 and fill_ready=1 with fill_addr index/tag equal to lookup_addr, bypass: hit=1, hit_data=fill_data same cycle.
REQ-020 SHALL, on a hit at posedge, set LRU of that set to point at the other way.
REQ-021 SHALL, on an accepted fill, write valid=1, tag, data into: the way already holding the tag if present; else way0 if invalid; else way1 if invalid; else the LRU way.
REQ-022 SHALL, on an accepted fill, set LRU to point at the way not written; fill LRU update overrides a same-set hit LRU update.
REQ-023 SHALL never hold the same tag valid in both ways of a set.
REQ-024 SHALL implement FSM states IDLE and FLUSH; fill_ready = 1 in IDLE, 0 in FLUSH.
REQ-025 SHALL in IDLE on flush_req=1 move to FLUSH, clear counter to 0; a fill presented that same cycle is not accepted (fill_ready=0 when flush_req=1).
REQ-026 SHALL in FLUSH clear valid (both ways) and LRU of set[counter] each cycle, increment counter, return to IDLE after set 2^INDEX_W-1 is cleared; walk = 2^INDEX_W cycles.
REQ-027 SHALL assert flush_busy=1 exactly while in FLUSH; hit=0 throughout FLUSH.
REQ-028 SHALL ignore flush_req while in FLUSH (no restart).
REQ-029 SHALL let counter width be INDEX_W bits; wrap to 0 terminates the walk.

Reset
REQ-030 SHALL on rst=1 at posedge clear all valid and LRU bits in one cycle, state=IDLE, counter=0; tag/data arrays not reset.
REQ-031 SHALL force hit=0, hit_data=0, flush_busy=0, fill_ready=0 combinationally while rst=1.
REQ-032 SHALL abort an in-progress flush on rst (reset clears everything anyway).

Verification
REQ-033 SHALL cover: after reset, lookup 0x0000_1000 -> hit=0; fill 0x1000/0xDEADBEEF then lookup -> hit=1, data 0xDEADBEEF.
REQ-034 SHALL cover: fill 0x1000 and 0x2000 (same set, INDEX_W=6), hit 0x1000, fill 0x3000 -> 0x2000 evicted, 0x1000 and 0x3000 hit.
REQ-035 SHALL cover: fill 0x1000/A then 0x1000/B -> lookup returns B, other way still holds prior content/invalid.
REQ-036 SHALL cover: lookup 0x4000 in same cycle as fill 0x4000/0x12345678 -> hit=1, data 0x12345678 that cycle.
REQ-037 SHALL cover: fill lines, pulse flush_req -> flush_busy=1 for 64 cycles, fill_ready=0, then all prior lines miss.
REQ-038 SHALL cover: rst asserted at flush cycle 10 -> next cycle flush_busy=0, all lookups miss, fills accepted.
